// File: rtl/axi_rd_burst_streamer_if.sv
// ---------------------------------------------------------------------------
// axi_rd_burst_streamer_if
// Bundles every bus of the read streamer into one interface:
//   command   : cmd_valid/cmd_ready/cmd_addr/cmd_len
//   AXI AR    : araddr/arlen/arsize/arburst/arid/arvalid/arready
//   AXI R     : rdata/rresp/rlast/rid/rvalid/rready
//   stream    : m_data/m_last/m_valid/m_ready
//   status    : busy/err
// modport master : the streamer itself (issues AR, sinks R, sources stream)
// modport slave  : the environment around it (command source, memory, sink)
// ---------------------------------------------------------------------------
interface axi_rd_burst_streamer_if #(
  parameter int ADDR_WTH = 32,
  parameter int DATA_WTH = 256,
  parameter int ID_WIDTH = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_WTH-1:0] cmd_addr;
  logic [15:0]         cmd_len;

  logic [ADDR_WTH-1:0] araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;
  logic                arvalid;
  logic                arready;

  logic [DATA_WTH-1:0] rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_WIDTH-1:0] rid;
  logic                rvalid;
  logic                rready;

  logic [DATA_WTH-1:0] m_data;
  logic                m_last;
  logic                m_valid;
  logic                m_ready;

  logic                busy;
  logic                err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, rvalid,
    output rready,
    output m_data, m_last, m_valid,
    input  m_ready,
    output busy, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, rvalid,
    input  rready,
    input  m_data, m_last, m_valid,
    output m_ready,
    input  busy, err
  );
endinterface

// File: rtl/axi_rd_burst_streamer.sv
// ---------------------------------------------------------------------------
// axi_rd_burst_streamer
// AXI4 read master: one command (start address, beat count) is split into
// INCR bursts that never cross a 4 KiB page and never exceed MAX_BEATS.
// Returned beats are buffered in a local FIFO and leave as a valid/ready
// stream whose last flag marks the final beat of the whole command.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : axi_rd_burst_streamer_if.master (command, AR, R, stream, status)
// ---------------------------------------------------------------------------
module axi_rd_burst_streamer #(
  parameter int ADDR_WTH   = 32,
  parameter int DATA_WTH   = 256,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BEATS  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_ID      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  axi_rd_burst_streamer_if.master   bus
);

  localparam int BPB = DATA_WTH / 8;
  localparam int BSH = $clog2(BPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ARQ,
    S_RDATA,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WTH-1:0] addr_q, addr_d;
  logic [15:0]         remain_q, remain_d;
  logic [8:0]          beats_q, beats_d;
  logic [8:0]          bcnt_q, bcnt_d;
  logic                err_q, err_d;

  // FIFO storage: {last, data} per entry
  logic [DATA_WTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         cnt_q;

  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [PW:0]         free_slots;

  logic [12:0]         to_page_end;
  logic [12:0]         page_beats;
  logic [8:0]          lim_beats;
  logic [8:0]          beats_calc;
  logic                credit_ok;
  logic                last_beat;
  logic                final_burst;
  logic                beat_bad;

  assign fifo_full  = (cnt_q == DEPTH_L);
  assign fifo_empty = (cnt_q == '0);
  assign free_slots = DEPTH_L - cnt_q;

  // Only beats that belong to a burst we issued are stored; anything arriving
  // in other states (e.g. stragglers after a reset) is accepted and dropped.
  assign push = bus.rvalid & bus.rready & (state_q == S_RDATA);
  assign pop  = bus.m_valid & bus.m_ready;

  // Beats left before the 4 KiB page boundary; 13 bits so an address at a
  // page start yields a full page rather than zero.
  assign to_page_end = 13'h1000 - {1'b0, addr_q[11:0]};
  assign page_beats  = to_page_end >> BSH;

  assign lim_beats  = (13'(MAX_BEATS) < page_beats) ? 9'(MAX_BEATS) : page_beats[8:0];
  assign beats_calc = ({7'b0, lim_beats} < remain_q) ? lim_beats : remain_q[8:0];

  // The whole burst must fit in the FIFO before AR goes out, so R never stalls.
  assign credit_ok = (32'(free_slots) >= 32'(beats_calc));

  assign last_beat   = (bcnt_q == (beats_q - 9'd1));
  assign final_burst = (remain_q == {7'b0, beats_q});
  assign beat_bad    = (bus.rresp != 2'b00) ||
                       (bus.rid != ID_WIDTH'(RD_ID)) ||
                       (bus.rlast != last_beat);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      beats_q  <= '0;
      bcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beats_q  <= beats_d;
      bcnt_q   <= bcnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beats_d  = beats_q;
    bcnt_d   = bcnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr & ~ADDR_WTH'(BPB - 1);
          remain_d = bus.cmd_len;
          err_d    = 1'b0;
          state_d  = (bus.cmd_len == 16'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        beats_d = beats_calc;
        if (credit_ok) state_d = S_ARQ;
      end
      S_ARQ: begin
        if (bus.arready) begin
          bcnt_d  = '0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (push) begin
          if (beat_bad) err_d = 1'b1;
          // The burst ends on the beat count, whatever rlast says.
          if (last_beat) begin
            addr_d   = addr_q + (ADDR_WTH'(beats_q) << BSH);
            remain_d = remain_q - 16'(beats_q);
            bcnt_d   = '0;
            state_d  = (remain_q != 16'(beats_q)) ? S_CALC : S_DONE;
          end else begin
            bcnt_d = bcnt_q + 9'd1;
          end
        end
      end
      S_DONE: begin
        if (fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {final_burst & last_beat, bus.rdata};
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.araddr    = addr_q;
  assign bus.arlen     = 8'(beats_q - 9'd1);
  assign bus.arsize    = 3'(BSH);
  assign bus.arburst   = 2'b01;
  assign bus.arid      = ID_WIDTH'(RD_ID);
  assign bus.arvalid   = (state_q == S_ARQ);
  assign bus.rready    = ~fifo_full;
  // Head of FIFO is presented directly so a beat is visible the cycle after it lands.
  assign bus.m_data    = mem_q[rptr_q][DATA_WTH-1:0];
  assign bus.m_last    = mem_q[rptr_q][DATA_WTH];
  assign bus.m_valid   = ~fifo_empty;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_axi_rd_burst_streamer.sv
module tb_axi_rd_burst_streamer;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rd_burst_streamer_if #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW)) bus ();

  axi_rd_burst_streamer #(
    .ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW),
    .MAX_BEATS(16), .FIFO_DEPTH(16), .RD_ID(0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; int min_pops; } ar_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } rb_t;
  typedef struct { logic [DW-1:0] data; logic last; } s_exp_t;

  ar_exp_t exp_ar[$];
  s_exp_t  exp_s[$];
  rb_t     r_q[$];

  int total = 0;
  int bad = 0;
  int pops = 0;
  int pops_at_cmd = 0;
  int ar_seen = 0;
  int mr_mode = 0;
  int inj_idx = -1;
  int rbeat_cnt = 0;
  bit r_busy = 1'b0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111, a, ~a, a ^ 32'hA5A5_A5A5, a - 32'h1};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic push_burst(input logic [AW-1:0] a, input int nb, input bit fin, input int mp);
    ar_exp_t e;
    s_exp_t  s;
    e.addr = a; e.len = 8'(nb - 1); e.min_pops = mp;
    exp_ar.push_back(e);
    for (int i = 0; i < nb; i++) begin
      s.data = pat(a + 32'(i * 32));
      s.last = fin && (i == nb - 1);
      exp_s.push_back(s);
    end
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [15:0] l);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin n++; @(negedge clk); end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    pops_at_cmd = pops;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    $display("cmd addr=%08h len=%0d", a, l);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 5000) begin n++; @(negedge clk); end
    chk("busy_fall", bus.busy, 1'b0);
  endtask

  // Environment drivers: AR ready pattern and stream ready modes
  initial begin
    int cyc;
    cyc = 0;
    bus.arready = 1'b0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.arready = (cyc % 3 != 0);
      case (mr_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ~bus.m_ready;
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Memory model: answers each accepted AR with its beats
  initial begin
    rb_t b;
    bit  hs;
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rid = '0;
    forever begin
      @(posedge clk); #1;
      if (r_q.size() != 0) begin
        b = r_q.pop_front();
        r_busy = 1'b1;
        for (int i = 0; i <= int'(b.len); i++) begin
          bus.rvalid = 1'b1;
          bus.rdata  = pat(b.addr + 32'(i * 32));
          bus.rlast  = (i == int'(b.len));
          bus.rresp  = (rbeat_cnt == inj_idx) ? 2'd2 : 2'd0;
          bus.rid    = '0;
          do begin
            @(negedge clk); hs = bus.rready;
            @(posedge clk); #1;
          end while (!hs);
          rbeat_cnt++;
          bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
          if (i % 4 == 2) begin @(posedge clk); #1; end
        end
        r_busy = 1'b0;
      end
    end
  end

  // Monitor: AR and stream checks against the scoreboard queues
  initial begin
    ar_exp_t e;
    rb_t     rb;
    s_exp_t  s;
    forever begin
      @(negedge clk);
      if (!rst && bus.arvalid) begin
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got addr=%08h len=%0d want none", bus.araddr, bus.arlen);
        end else begin
          e = exp_ar[0];
          chk("ar_addr", bus.araddr, e.addr);
          chk("ar_len", bus.arlen, e.len);
          if (bus.arready) begin
            chk("ar_size", bus.arsize, 3'd5);
            chk("ar_burst", bus.arburst, 2'b01);
            chk("ar_id", bus.arid, 4'd0);
            chk("ar_credit", ((pops - pops_at_cmd) >= e.min_pops), 1'b1);
            void'(exp_ar.pop_front());
            rb.addr = bus.araddr; rb.len = bus.arlen;
            r_q.push_back(rb);
            ar_seen++;
            $display("ar addr=%08h len=%0d", bus.araddr, bus.arlen);
          end
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_s.size() == 0) begin
          total++; bad++;
          $display("FAIL s_unexpected: got data=%0h want none", bus.m_data);
        end else begin
          s = exp_s.pop_front();
          chk("s_data", bus.m_data, s.data);
          chk("s_last", bus.m_last, s.last);
          $display("beat %0d last=%0b", pops, bus.m_last);
        end
        pops++;
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ar0;
    int p0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_rready", bus.rready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // single burst
    mr_mode = 0;
    push_burst(32'h8000_0000, 4, 1'b1, 0);
    start_cmd(32'h8000_0000, 16'd4);
    wait_idle(n);
    chk("t1_m_valid", bus.m_valid, 1'b0);
    chk("t1_drained", exp_s.size(), 0);
    chk("t1_err", bus.err, 1'b0);

    // 4 KiB crossing, toggling stream ready
    mr_mode = 1;
    push_burst(32'h8000_0FC0, 2, 1'b0, 0);
    push_burst(32'h8000_1000, 2, 1'b1, 0);
    start_cmd(32'h8000_0FC0, 16'd4);
    wait_idle(n);
    chk("t2_drained", exp_s.size(), 0);

    // MAX_BEATS split
    mr_mode = 0;
    push_burst(32'h8000_0000, 16, 1'b0, 0);
    push_burst(32'h8000_0200, 16, 1'b0, 0);
    push_burst(32'h8000_0400, 8, 1'b1, 0);
    start_cmd(32'h8000_0000, 16'd40);
    wait_idle(n);
    chk("t3_drained", exp_s.size(), 0);

    // zero length
    ar0 = ar_seen;
    start_cmd(32'h8000_0100, 16'd0);
    wait_idle(n);
    chk("t4_busy_cycles", (n >= 1 && n <= 2), 1'b1);
    chk("t4_no_ar", ar_seen - ar0, 0);
    chk("t4_m_valid", bus.m_valid, 1'b0);

    // stalled sink: second AR waits for a full FIFO of credit
    mr_mode = 2;
    ar0 = ar_seen;
    push_burst(32'h8000_4000, 16, 1'b0, 0);
    push_burst(32'h8000_4200, 16, 1'b1, 16);
    start_cmd(32'h8000_4000, 16'd32);
    repeat (80) @(negedge clk);
    chk("t5_one_ar", ar_seen - ar0, 1);
    chk("t5_ar_held", bus.arvalid, 1'b0);
    chk("t5_m_valid", bus.m_valid, 1'b1);
    chk("t5_full", bus.rready, 1'b0);
    mr_mode = 0;
    wait_idle(n);
    chk("t5_drained", exp_s.size(), 0);

    // error response on beat 2 of 4, cleared by next command (unaligned address)
    inj_idx = rbeat_cnt + 1;
    push_burst(32'h8000_3000, 4, 1'b1, 0);
    start_cmd(32'h8000_3000, 16'd4);
    wait_idle(n);
    chk("t6_err_set", bus.err, 1'b1);
    inj_idx = -1;
    push_burst(32'h8000_3000, 1, 1'b1, 0);
    start_cmd(32'h8000_3013, 16'd1);
    @(negedge clk);
    chk("t6_err_clr", bus.err, 1'b0);
    wait_idle(n);
    chk("t6_err_stay0", bus.err, 1'b0);

    // reset mid-burst; stragglers must be dropped
    push_burst(32'h8000_2000, 16, 1'b1, 0);
    p0 = pops;
    start_cmd(32'h8000_2000, 16'd16);
    n = 0;
    while ((pops - p0) < 3 && n < 500) begin n++; @(negedge clk); end
    chk("t7_progress", ((pops - p0) >= 3), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t7_rst_busy", bus.busy, 1'b0);
    chk("t7_rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("t7_rst_m_valid", bus.m_valid, 1'b0);
    chk("t7_rst_rready", bus.rready, 1'b1);
    exp_s.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while ((r_busy || r_q.size() != 0) && n < 500) begin n++; @(negedge clk); end
    @(negedge clk);
    chk("t7_dropped", bus.m_valid, 1'b0);
    chk("t7_idle", bus.busy, 1'b0);

    // recovery after reset
    push_burst(32'h8000_5000, 2, 1'b1, 0);
    start_cmd(32'h8000_5000, 16'd2);
    wait_idle(n);

    chk("end_ar_q", exp_ar.size(), 0);
    chk("end_s_q", exp_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
